// File: rtl/xor_checksum_unit_pkg.sv
// Shared types for the XOR checksum unit: FSM state encoding.
package xor_checksum_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/xor_n_bits.sv
// Parametrised combinational bitwise XOR of two WIDTH-bit words.
module xor_n_bits #(
  parameter int unsigned WIDTH = 5
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
);

  assign out = a ^ b;

endmodule

// File: rtl/xor_checksum_unit.sv
// Streaming XOR checksum: folds a packet of words into one result with a saturating beat count.
module xor_checksum_unit
  import xor_checksum_unit_pkg::*;
#(
  parameter int unsigned     WIDTH = 5,
  parameter int unsigned     CNT_W = 8,
  parameter logic [WIDTH-1:0] SEED = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_parity
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_parity_q, out_parity_d;

  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  // Single XOR instance serves both the running accumulator and the final capture.
  xor_n_bits #(
    .WIDTH(WIDTH)
  ) u_xor (
    .out(acc_next),
    .a  (acc_q),
    .b  (in_data)
  );

  assign in_ready = (state_q != StDone);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;
    out_count_d  = out_count_q;
    out_parity_d = out_parity_q;

    case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          if (in_last) begin
            out_sum_d    = acc_next;
            out_count_d  = cnt_inc;
            out_parity_d = ^acc_next;
            out_valid_d  = 1'b1;
            state_d      = StDone;
          end else begin
            acc_d   = acc_next;
            cnt_d   = cnt_inc;
            state_d = StAccum;
          end
        end
      end
      StDone: begin
        // Release only; in_ready is low here, so no beat can be taken this cycle.
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = SEED;
          cnt_d       = '0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        acc_d       = SEED;
        cnt_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      acc_q        <= SEED;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_count_q  <= '0;
      out_parity_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_count_q  <= out_count_d;
      out_parity_q <= out_parity_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_count  = out_count_q;
  assign out_parity = out_parity_q;

endmodule

// File: tb/tb_xor_checksum_unit.sv
// Self-checking bench: directed scenarios plus randomized packets against a packet-level model.
module tb_xor_checksum_unit;

  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_last, out_ready;
  logic [W-1:0] in_data, out_sum;
  logic [7:0]   out_count;
  logic         in_ready, out_valid, out_parity;

  logic         s_in_valid, s_in_last, s_out_ready;
  logic [W-1:0] s_in_data, s_out_sum;
  logic [1:0]   s_out_count;
  logic         s_in_ready, s_out_valid, s_out_parity;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] pkt[$];

  always #5 clk = ~clk;

  xor_checksum_unit #(
    .WIDTH(W),
    .CNT_W(8),
    .SEED (5'b00000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_parity(out_parity)
  );

  xor_checksum_unit #(
    .WIDTH(W),
    .CNT_W(2),
    .SEED (5'b10101)
  ) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_last   (s_in_last),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_sum   (s_out_sum),
    .out_count (s_out_count),
    .out_parity(s_out_parity)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packet-level reference: checksum is SEED XOR every word, count clips at the counter maximum.
  function automatic logic [W-1:0] model_sum(input logic [W-1:0] seed);
    logic [W-1:0] s;
    s = seed;
    foreach (pkt[i]) s = s ^ pkt[i];
    return s;
  endfunction

  function automatic int model_count(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  // Drives pkt onto the main DUT with random idle gaps; ok drops if in_ready never appears.
  task automatic send_pkt(input int max_gap, output bit ok);
    int n;
    ok = 1'b1;
    foreach (pkt[i]) begin
      repeat ((max_gap > 0) ? $urandom_range(0, max_gap) : 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == pkt.size() - 1);
      n = 0;
      while (!in_ready && n < 50) begin
        step();
        n++;
      end
      if (!in_ready) ok = 1'b0;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 5'b10110; in_last = 1'b1; out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_data = 5'b00111; s_in_last = 1'b1; s_out_ready = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_sum !== 5'b00000) begin errors++;
      $display("FAIL reset_out_sum got %b want 00000", out_sum); end
    checks++; if (out_count !== 8'd0) begin errors++;
      $display("FAIL reset_out_count got %0d want 0", out_count); end
    checks++; if (out_parity !== 1'b0) begin errors++;
      $display("FAIL reset_out_parity got %b want 0", out_parity); end
    checks++; if (s_out_sum !== 5'b00000 || s_out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_sat_outputs got sum %b valid %b want 00000 0", s_out_sum, s_out_valid);
    end
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_no_capture got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_two_beat();
    bit ok;
    out_ready = 1'b1;
    pkt = '{5'b11111, 5'b00111};
    send_pkt(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL two_beat_timeout got 0 want 1"); end
    checks++; if (out_valid !== 1'b1 || out_sum !== 5'b11000) begin errors++;
      $display("FAIL two_beat_result got valid %b sum %b want 1 11000", out_valid, out_sum); end
    checks++; if (out_count !== 8'd2 || out_parity !== 1'b0) begin errors++;
      $display("FAIL two_beat_cnt_par got %0d %b want 2 0", out_count, out_parity); end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL two_beat_release got valid %b ready %b want 0 1", out_valid, in_ready); end
    checks++; if (out_sum !== 5'b11000) begin errors++;
      $display("FAIL two_beat_hold_sum got %b want 11000", out_sum); end
  endtask

  task automatic test_cancel_single();
    bit ok;
    out_ready = 1'b1;
    pkt = '{5'b11000, 5'b11000};
    send_pkt(0, ok);
    checks++; if (!ok || out_valid !== 1'b1 || out_sum !== 5'b00000 || out_parity !== 1'b0)
    begin errors++;
      $display("FAIL cancel_result got ok %b valid %b sum %b par %b want 1 1 00000 0",
               ok, out_valid, out_sum, out_parity); end
    step();
    pkt = '{5'b10000};
    send_pkt(0, ok);
    checks++; if (!ok || out_valid !== 1'b1 || out_sum !== 5'b10000) begin errors++;
      $display("FAIL single_sum got ok %b valid %b sum %b want 1 1 10000", ok, out_valid, out_sum);
    end
    checks++; if (out_count !== 8'd1 || out_parity !== 1'b1) begin errors++;
      $display("FAIL single_cnt_par got %0d %b want 1 1", out_count, out_parity); end
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [W-1:0] d1;
    out_ready = 1'b0;
    pkt = '{5'b00010};
    send_pkt(0, ok);
    checks++; if (!ok || out_valid !== 1'b1) begin errors++;
      $display("FAIL bp_valid got ok %b valid %b want 1 1", ok, out_valid); end
    d1 = 5'($urandom_range(1, 31));
    in_valid = 1'b1; in_data = d1; in_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_sum !== 5'b00010 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid %b sum %b ready %b want 1 00010 0",
                 c, out_valid, out_sum, in_ready); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 5'b00010) begin errors++;
      $display("FAIL bp_release got valid %b ready %b sum %b want 0 1 00010",
               out_valid, in_ready, out_sum); end
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_sum !== d1 || out_count !== 8'd1) begin errors++;
      $display("FAIL bp_next_beat got valid %b sum %b cnt %0d want 1 %b 1",
               out_valid, out_sum, out_count, d1); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_gaps_reset();
    bit ok;
    out_ready = 1'b1;
    pkt = '{5'b00001};
    in_valid = 1'b1; in_data = 5'b00001; in_last = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    in_valid = 1'b1; in_data = 5'b00100;
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    pkt = '{5'b01000};
    send_pkt(0, ok);
    checks++; if (!ok || out_valid !== 1'b1 || out_sum !== 5'b01000 || out_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_mid_pkt got valid %b sum %b cnt %0d want 1 01000 1",
               out_valid, out_sum, out_count); end
    step();
    pkt = '{5'b00001, 5'b00100, 5'b01000};
    send_pkt(2, ok);
    checks++; if (!ok || out_valid !== 1'b1 || out_sum !== model_sum(5'b00000) ||
                  out_count !== 8'd3) begin errors++;
      $display("FAIL gaps_pkt got valid %b sum %b cnt %0d want 1 %b 3",
               out_valid, out_sum, out_count, model_sum(5'b00000)); end
    step();
  endtask

  task automatic test_random();
    bit ok;
    int len, hold;
    logic [W-1:0] exp_sum;
    for (int p = 0; p < 25; p++) begin
      pkt.delete();
      len = (p == 24) ? 260 : $urandom_range(1, 12);
      for (int i = 0; i < len; i++) pkt.push_back(W'($urandom()));
      exp_sum = model_sum(5'b00000);
      out_ready = 1'b0;
      send_pkt((p == 24) ? 0 : 2, ok);
      checks++; if (!ok || out_valid !== 1'b1 || out_sum !== exp_sum ||
                    out_parity !== ^exp_sum) begin errors++;
        $display("FAIL rand_pkt %0d got valid %b sum %b par %b want 1 %b %b",
                 p, out_valid, out_sum, out_parity, exp_sum, ^exp_sum); end
      checks++; if (out_count !== 8'(model_count(len, 255))) begin errors++;
        $display("FAIL rand_cnt %0d got %0d want %0d", p, out_count, model_count(len, 255)); end
      hold = $urandom_range(0, 3);
      for (int c = 0; c < hold; c++) begin
        step();
        checks++; if (out_valid !== 1'b1 || out_sum !== exp_sum) begin errors++;
          $display("FAIL rand_hold %0d got valid %b sum %b want 1 %b",
                   p, out_valid, out_sum, exp_sum); end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_saturation();
    s_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1; s_in_data = 5'b00001; s_in_last = (i == 4);
      checks++; if (s_in_ready !== 1'b1) begin errors++;
        $display("FAIL sat_in_ready beat %0d got %b want 1", i, s_in_ready); end
      step();
    end
    s_in_valid = 1'b0; s_in_last = 1'b0;
    checks++; if (s_out_valid !== 1'b1 || s_out_sum !== 5'b10100) begin errors++;
      $display("FAIL sat_sum got valid %b sum %b want 1 10100", s_out_valid, s_out_sum); end
    checks++; if (s_out_count !== 2'd3 || s_out_parity !== 1'b0) begin errors++;
      $display("FAIL sat_cnt_par got %0d %b want 3 0", s_out_count, s_out_parity); end
    s_out_ready = 1'b1;
    step();
    s_in_valid = 1'b1; s_in_data = 5'b00000; s_in_last = 1'b1;
    step();
    s_in_valid = 1'b0; s_in_last = 1'b0;
    checks++; if (s_out_valid !== 1'b1 || s_out_sum !== 5'b10101 || s_out_count !== 2'd1 ||
                  s_out_parity !== 1'b1) begin errors++;
      $display("FAIL sat_seed_reload got valid %b sum %b cnt %0d par %b want 1 10101 1 1",
               s_out_valid, s_out_sum, s_out_count, s_out_parity); end
    step();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_out_ready = 1'b0;
    #1;
    test_reset();
    test_two_beat();
    test_cancel_single();
    test_backpressure();
    test_gaps_reset();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
